// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery charge controller: state encoding,
// code widths, LSB scaling and default thresholds.
package batcharger_pkg;

  typedef enum logic [2:0] {IDLE, TC, CC, CV, END, FAULT} state_t;

  localparam int CODE_W = 8;
  localparam int ISET_W = 8;
  localparam int SEL_W  = 4;
  localparam int PROD_W = 12;
  localparam int TMR_W  = 32;

  localparam int VBAT_LSB_MV  = 20;
  localparam int IBAT_LSB_MA  = 5;
  localparam int CAP_STEP_MAH = 50;

  localparam logic [CODE_W-1:0] VCUTOFF_DEF = 8'd150;
  localparam logic [CODE_W-1:0] VPRESET_DEF = 8'd210;
  localparam logic [CODE_W-1:0] VRECHG_DEF  = 8'd200;
  localparam logic [CODE_W-1:0] TLOW_DEF    = 8'd31;
  localparam logic [CODE_W-1:0] TEMP_HI_DEF = 8'd140;

  localparam int ITERM_DIV_DEF = 10;
  localparam int DEB_N_DEF     = 3;

  localparam logic [TMR_W-1:0] TC_TMAX_DEF = 32'd1_000_000;
  localparam logic [TMR_W-1:0] CV_TMAX_DEF = 32'd2_000_000;

endpackage

// File: rtl/batcharger_debounce.sv
// Counts consecutive qualifying sample strobes; done pulses on the DEB_N-th one
// and the count restarts, so each transition needs a fresh run of samples.
module batcharger_debounce
  import batcharger_pkg::*;
#(
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic qualify,
  input  logic strobe,
  input  logic clear,
  output logic done
);

  localparam int CW = (DEB_N > 2) ? $clog2(DEB_N) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_N - 1);

  logic [CW-1:0] cnt;

  assign done = strobe && qualify && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (strobe) begin
      if (!qualify || done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/batcharger_ctrl.sv
// Trickle / constant-current / constant-voltage charge controller: registers ADC
// samples, debounces every sample-driven transition and drives registered mode flags.
module batcharger_ctrl
  import batcharger_pkg::*;
#(
  parameter int                 DATA_W    = CODE_W,
  parameter logic [DATA_W-1:0]  VCUTOFF   = VCUTOFF_DEF,
  parameter logic [DATA_W-1:0]  VPRESET   = VPRESET_DEF,
  parameter logic [DATA_W-1:0]  VRECHG    = VRECHG_DEF,
  parameter logic [DATA_W-1:0]  TLOW      = TLOW_DEF,
  parameter logic [DATA_W-1:0]  TEMP_HI   = TEMP_HI_DEF,
  parameter int                 ITERM_DIV = ITERM_DIV_DEF,
  parameter int                 DEB_N     = DEB_N_DEF,
  parameter logic [TMR_W-1:0]   TC_TMAX   = TC_TMAX_DEF,
  parameter logic [TMR_W-1:0]   CV_TMAX   = CV_TMAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] vbat_code,
  input  logic [DATA_W-1:0] ibat_code,
  input  logic [DATA_W-1:0] vtemp_code,
  output logic [ISET_W-1:0] iset,
  output logic              tc,
  output logic              cc,
  output logic              cv,
  output logic              done,
  output logic              fault
);

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  // C/10 in TC, 1C in CC/CV (LSB 5 mA, C = 50 mAh per sel step); zero elsewhere
  function automatic logic [ISET_W-1:0] iset_for(input state_t s, input logic [SEL_W-1:0] sl);
    logic [ISET_W-1:0] c10;
    c10 = {{(ISET_W-SEL_W){1'b0}}, sl} + 1'b1;
    case (s)
      TC:      return c10;
      CC, CV:  return c10 * 8'd10;
      default: return '0;
    endcase
  endfunction

  state_t             state;
  state_t             nxt;
  logic [DATA_W-1:0]  vbat_p0;
  logic [DATA_W-1:0]  ibat_p0;
  logic [DATA_W-1:0]  vtemp_p0;
  logic               vld_p0;
  logic [TMR_W-1:0]   tc_timer;
  logic [TMR_W-1:0]   cv_timer;
  logic               temp_bad;
  logic               iterm_hit;
  logic [PROD_W-1:0]  iterm_prod;
  logic [ISET_W-1:0]  cc_set;
  logic               tc_tmo;
  logic               cv_tmo;
  logic               qualify;
  logic               deb_done;

  // Stage p0: sample capture on strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      vbat_p0  <= '0;
      ibat_p0  <= '0;
      vtemp_p0 <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= sample_valid;
      if (sample_valid) begin
        vbat_p0  <= vbat_code;
        ibat_p0  <= ibat_code;
        vtemp_p0 <= vtemp_code;
      end
    end
  end

  assign temp_bad   = (vtemp_p0 < TLOW) || (vtemp_p0 > TEMP_HI);
  assign cc_set     = iset_for(CC, sel);
  assign iterm_prod = PROD_W'(ibat_p0) * PROD_W'(ITERM_DIV);
  assign iterm_hit  = iterm_prod < PROD_W'(cc_set);
  assign tc_tmo     = (state == TC) && (tc_timer == TC_TMAX - 1'b1);
  assign cv_tmo     = (state == CV) && (cv_timer == CV_TMAX - 1'b1);

  always_comb begin
    qualify = 1'b0;
    case (state)
      IDLE:    qualify = 1'b1;
      TC:      qualify = temp_bad || (vbat_p0 >= VCUTOFF);
      CC:      qualify = temp_bad || (vbat_p0 >= VPRESET);
      CV:      qualify = temp_bad || iterm_hit;
      END:     qualify = vbat_p0 < VRECHG;
      FAULT:   qualify = !temp_bad;
      default: qualify = 1'b0;
    endcase
  end

  batcharger_debounce #(
    .DEB_N(DEB_N)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .qualify (qualify),
    .strobe  (vld_p0),
    .clear   (!en || tc_tmo || cv_tmo),
    .done    (deb_done)
  );

  // Temperature faults outrank the normal exit; timeouts act without debounce
  always_comb begin
    nxt = state;
    if (!en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (deb_done) begin
          if (temp_bad)               nxt = FAULT;
          else if (vbat_p0 < VCUTOFF) nxt = TC;
          else if (vbat_p0 < VPRESET) nxt = CC;
          else                        nxt = END;
        end
        TC: begin
          if (deb_done)    nxt = temp_bad ? FAULT : CC;
          else if (tc_tmo) nxt = FAULT;
        end
        CC: if (deb_done) nxt = temp_bad ? FAULT : CV;
        CV: begin
          if (deb_done)    nxt = temp_bad ? FAULT : END;
          else if (cv_tmo) nxt = END;
        end
        END:     if (deb_done) nxt = IDLE;
        FAULT:   if (deb_done) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_timer <= '0;
      cv_timer <= '0;
    end else begin
      tc_timer <= (state == TC) ? sat_inc(tc_timer) : '0;
      cv_timer <= (state == CV) ? sat_inc(cv_timer) : '0;
    end
  end

  // Stage p1: state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      iset  <= '0;
      tc    <= 1'b0;
      cc    <= 1'b0;
      cv    <= 1'b0;
      done  <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      iset  <= iset_for(nxt, sel);
      tc    <= (nxt == TC);
      cc    <= (nxt == CC);
      cv    <= (nxt == CV);
      done  <= (nxt == END);
      fault <= (nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed bench for batcharger_ctrl: expected output changes are queued with the
// cycle they must appear in, and a monitor process checks every change it sees.
`timescale 1ns/1ps
module tb_batcharger_ctrl;
  import batcharger_pkg::*;

  localparam logic [12:0] V_IDLE = 13'd0;
  localparam logic [12:0] V_TC9  = {5'b10000, 8'd9};
  localparam logic [12:0] V_CC90 = {5'b01000, 8'd90};
  localparam logic [12:0] V_CC20 = {5'b01000, 8'd20};
  localparam logic [12:0] V_CV90 = {5'b00100, 8'd90};
  localparam logic [12:0] V_END  = {5'b00010, 8'd0};
  localparam logic [12:0] V_FLT  = {5'b00001, 8'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  sel;
  logic        sample_valid;
  logic [7:0]  vbat_code;
  logic [7:0]  ibat_code;
  logic [7:0]  vtemp_code;
  logic [7:0]  iset;
  logic        tc, cc, cv, done, fault;
  logic [12:0] outv;

  int unsigned cyc = 0;
  int unsigned cap;
  int          total = 0;
  int          bad = 0;
  logic [12:0] exp_v[$];
  int unsigned exp_c[$];
  logic [7:0]  ramp [11] = '{8'd130, 8'd140, 8'd150, 8'd160, 8'd170, 8'd180,
                             8'd190, 8'd200, 8'd210, 8'd212, 8'd215};
  logic [7:0]  brk [5] = '{8'd215, 8'd215, 8'd180, 8'd215, 8'd215};

  assign outv = {tc, cc, cv, done, fault, iset};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  batcharger_ctrl #(
    .TC_TMAX (32'd1000),
    .CV_TMAX (32'd100000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sel          (sel),
    .sample_valid (sample_valid),
    .vbat_code    (vbat_code),
    .ibat_code    (ibat_code),
    .vtemp_code   (vtemp_code),
    .iset         (iset),
    .tc           (tc),
    .cc           (cc),
    .cv           (cv),
    .done         (done),
    .fault        (fault)
  );

  task automatic push(input logic [12:0] v, input int unsigned c);
    exp_v.push_back(v);
    exp_c.push_back(c);
  endtask

  // Called at posedge+1; the sample is captured on the next edge and any
  // resulting change must show one edge later.
  task automatic strobe(input logic [7:0] v, input logic [7:0] i, input logic [7:0] t,
                        input logic chg, input logic [12:0] ev);
    vbat_code = v;
    ibat_code = i;
    vtemp_code = t;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    cap = cyc;
    if (chg) push(ev, cap + 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string nm, input logic [12:0] ev);
    total++;
    if (outv !== ev) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, outv, ev, cyc);
    end
  endtask

  task automatic run_monitor();
    logic [12:0] prev;
    logic [12:0] cur;
    logic [12:0] e;
    int unsigned c;
    prev = outv;
    forever begin
      @(negedge clk);
      cur = outv;
      if (cur !== prev) begin
        if (exp_v.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: got %h at cycle %0d expected no change", cur, cyc);
        end else begin
          e = exp_v.pop_front();
          c = exp_c.pop_front();
          total++;
          if (cur !== e) begin
            bad++;
            $display("FAIL out_value: got %h expected %h at cycle %0d", cur, e, cyc);
          end
          total++;
          if (cyc != c) begin
            bad++;
            $display("FAIL out_cycle: value %h seen at cycle %0d expected cycle %0d", cur, cyc, c);
          end
          total++;
          if ($countones(cur[12:8]) > 1) begin
            bad++;
            $display("FAIL onehot: flags %b expected at most one set", cur[12:8]);
          end
        end
        prev = cur;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d expected summary", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    sel = 4'b1000;
    sample_valid = 1'b0;
    vbat_code = 8'd0;
    ibat_code = 8'd0;
    vtemp_code = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_now("reset_outputs", V_IDLE);
    fork
      run_monitor();
    join_none
    @(posedge clk); #1;
    en = 1'b1;

    // IDLE -> TC at C/10
    strobe(8'd120, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd120, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd120, 8'd50, 8'd80, 1'b1, V_TC9);

    // ramp: TC -> CC at 170 (3rd >=150), CC -> CV at 215 (3rd >=210)
    for (int i = 0; i < 11; i++)
      strobe(ramp[i], 8'd50, 8'd80, (i == 4) || (i == 10), (i == 4) ? V_CC90 : V_CV90);

    // CV terminates on low current, END recharges below 200, IDLE re-enters CC
    strobe(8'd212, 8'd8, 8'd80, 1'b0, V_IDLE);
    strobe(8'd212, 8'd8, 8'd80, 1'b0, V_IDLE);
    strobe(8'd212, 8'd8, 8'd80, 1'b1, V_END);
    strobe(8'd195, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd195, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd195, 8'd50, 8'd80, 1'b1, V_IDLE);
    strobe(8'd195, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd195, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd195, 8'd50, 8'd80, 1'b1, V_CC90);

    // capacity change mid-CC updates iset only
    sel = 4'b0001;
    push(V_CC20, cyc + 1);
    repeat (3) @(posedge clk);
    #1;
    sel = 4'b1000;
    push(V_CC90, cyc + 1);
    repeat (3) @(posedge clk);
    #1;

    // broken run of qualifying samples keeps CC
    for (int i = 0; i < 5; i++)
      strobe(brk[i], 8'd50, 8'd80, 1'b0, V_IDLE);
    check_now("deb_break_stays_cc", V_CC90);

    // over-temperature in CC, then recovery through IDLE back to CC
    strobe(8'd180, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd180, 8'd50, 8'd200, 1'b0, V_IDLE);
    strobe(8'd180, 8'd50, 8'd200, 1'b0, V_IDLE);
    strobe(8'd180, 8'd50, 8'd200, 1'b1, V_FLT);
    strobe(8'd180, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd180, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd180, 8'd50, 8'd80, 1'b1, V_IDLE);
    strobe(8'd180, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd180, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd180, 8'd50, 8'd80, 1'b1, V_CC90);

    // into CV, then disable drops straight to IDLE
    strobe(8'd215, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd215, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd215, 8'd50, 8'd80, 1'b1, V_CV90);
    en = 1'b0;
    push(V_IDLE, cyc + 1);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // trickle timeout: fault exactly 1000 cycles after TC becomes visible
    strobe(8'd100, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd100, 8'd50, 8'd80, 1'b0, V_IDLE);
    strobe(8'd100, 8'd50, 8'd80, 1'b1, V_TC9);
    push(V_FLT, cap + 1 + 1000);
    repeat (1010) @(posedge clk);
    #1;
    check_now("tc_timeout_fault", V_FLT);

    en = 1'b0;
    push(V_IDLE, cyc + 1);
    repeat (4) @(posedge clk);
    #1;

    total++;
    if (exp_v.size() != 0) begin
      bad++;
      $display("FAIL missing_transitions: pending %0d expected 0", exp_v.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
